wash_cycle_sequencer: RTL and testbench

//  Top-level phase sequencer for the washing machine: steps FILL -> WASH -> RINSE -> SPIN
//  and drives valve/motor/lock outputs, one programmable duration per phase. Owns one

---
 rtl/wash_cycle_sequencer_if.sv | 24 ++
 rtl/wash_cycle_sequencer.sv | 116 +++++++++++
 tb/tb_wash_cycle_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/wash_cycle_sequencer_if.sv
// Front-panel inputs and actuator/status outputs of the wash cycle sequencer.
interface wash_cycle_sequencer_if;
    logic       start;
    logic       pause;
    logic       double_wash;
    logic       door_closed;
    logic [2:0] state;
    logic       water_valve;
    logic       drain_valve;
    logic       motor_on;
    logic       door_lock;
    logic       phase_pre;
    logic       cycle_done;

    modport master (
        output start, pause, double_wash, door_closed,
        input  state, water_valve, drain_valve, motor_on, door_lock, phase_pre, cycle_done
    );

    modport slave (
        input  start, pause, double_wash, door_closed,
        output state, water_valve, drain_valve, motor_on, door_lock, phase_pre, cycle_done
    );
endinterface

// File: rtl/wash_cycle_sequencer.sv
// Phase sequencer FILL -> WASH (optionally twice) -> RINSE -> SPIN -> DONE driven by one
// shared phase timer that restarts at every phase boundary and freezes while paused.
module wash_cycle_sequencer #(
    parameter int unsigned FILL_T  = 4,
    parameter int unsigned WASH_T  = 8,
    parameter int unsigned RINSE_T = 6,
    parameter int unsigned SPIN_T  = 5,
    parameter int unsigned CNT_W   = 4
) (
    input logic                   clk,
    input logic                   rst,
    wash_cycle_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               pass_q, pass_d;
    logic               dw_q, dw_d;

    logic               active;
    logic               running;
    logic               phase_end;
    logic [CNT_W-1:0]   dur_m1;

    assign active    = (state_q == FILL) || (state_q == WASH) ||
                       (state_q == RINSE) || (state_q == SPIN);
    assign running   = active && !bus.pause && bus.door_closed;
    assign phase_end = running && (timer_q == dur_m1);

    always_comb begin
        dur_m1 = '0;
        case (state_q)
            FILL:    dur_m1 = CNT_W'(FILL_T - 1);
            WASH:    dur_m1 = CNT_W'(WASH_T - 1);
            RINSE:   dur_m1 = CNT_W'(RINSE_T - 1);
            SPIN:    dur_m1 = CNT_W'(SPIN_T - 1);
            default: dur_m1 = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pass_d  = pass_q;
        dw_d    = dw_q;
        if (running) begin
            timer_d = phase_end ? '0 : timer_q + CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (bus.start && bus.door_closed) begin
                    state_d = FILL;
                    dw_d    = bus.double_wash;
                    pass_d  = 1'b0;
                    timer_d = '0;
                end
            end
            FILL: begin
                if (phase_end) state_d = WASH;
            end
            WASH: begin
                // Second wash pass re-enters WASH with the timer already cleared above.
                if (phase_end) begin
                    if (dw_q && !pass_q) pass_d  = 1'b1;
                    else                 state_d = RINSE;
                end
            end
            RINSE: begin
                if (phase_end) state_d = SPIN;
            end
            SPIN: begin
                if (phase_end) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            pass_q  <= 1'b0;
            dw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pass_q  <= pass_d;
            dw_q    <= dw_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.water_valve = running && ((state_q == FILL) || (state_q == RINSE));
    assign bus.drain_valve = running && (state_q == SPIN);
    assign bus.motor_on    = running && ((state_q == WASH) || (state_q == RINSE) ||
                                         (state_q == SPIN));
    assign bus.door_lock   = active || (state_q == DONE);
    assign bus.phase_pre   = phase_end;
    assign bus.cycle_done  = (state_q == DONE);

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: directed table, multi-cycle scenarios and random stimulus
// against a phase-list reference model.
module tb_wash_cycle_sequencer;

    localparam int FILL_T  = 4;
    localparam int WASH_T  = 8;
    localparam int RINSE_T = 6;
    localparam int SPIN_T  = 5;

    logic clk = 1'b0;
    logic rst;

    wash_cycle_sequencer_if bus ();

    wash_cycle_sequencer #(
        .FILL_T (FILL_T),
        .WASH_T (WASH_T),
        .RINSE_T(RINSE_T),
        .SPIN_T (SPIN_T),
        .CNT_W  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining phases as a list of (state, duration), plus elapsed count.
    int m_st = 0;
    int m_el = 0;
    int ph_st[$];
    int ph_dur[$];

    // output vector layout: {state[2:0], water, drain, motor, lock, pre, done}
    function automatic logic [8:0] model_out(input logic p, input logic dc);
        logic [8:0] v;
        logic       run;
        int         st;
        st  = m_st;
        run = (st >= 1) && (st <= 4) && !p && dc;
        v[8:6] = st[2:0];
        v[5]   = run && (st == 1 || st == 3);
        v[4]   = run && (st == 4);
        v[3]   = run && (st >= 2);
        v[2]   = (st != 0);
        v[1]   = run && (m_el == ph_dur[0] - 1);
        v[0]   = (st == 5);
        return v;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic p,
                              input logic d, input logic dc);
        if (!r) begin
            m_st = 0;
            m_el = 0;
            ph_st.delete();
            ph_dur.delete();
        end else if (m_st == 0) begin
            if (s && dc) begin
                ph_st.push_back(1); ph_dur.push_back(FILL_T);
                ph_st.push_back(2); ph_dur.push_back(WASH_T);
                if (d) begin ph_st.push_back(2); ph_dur.push_back(WASH_T); end
                ph_st.push_back(3); ph_dur.push_back(RINSE_T);
                ph_st.push_back(4); ph_dur.push_back(SPIN_T);
                m_st = ph_st[0];
                m_el = 0;
            end
        end else if (m_st == 5) begin
            m_st = 0;
        end else if (!p && dc) begin
            m_el++;
            if (m_el == ph_dur[0]) begin
                void'(ph_st.pop_front());
                void'(ph_dur.pop_front());
                m_el = 0;
                m_st = (ph_st.size() > 0) ? ph_st[0] : 5;
            end
        end
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample at negedge, optionally compare with model, advance model.
    task automatic cyc(input logic r, input logic s, input logic p, input logic d,
                       input logic dc, input bit use_model, output logic [8:0] obs);
        rst             = r;
        bus.start       = s;
        bus.pause       = p;
        bus.double_wash = d;
        bus.door_closed = dc;
        @(negedge clk);
        obs = {bus.state, bus.water_valve, bus.drain_valve, bus.motor_on,
               bus.door_lock, bus.phase_pre, bus.cycle_done};
        if (use_model) chk("model_out", obs, model_out(p, dc));
        model_step(r, s, p, d, dc);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r, s, p, d, dc;
        logic [8:0] exp;
        string      name;
    } vec_t;

    // Full cycle from IDLE; mode 0 plain, 1 pause 3 cycles at WASH timer 5, 2 door open 2 in SPIN.
    task automatic run_cycle(input logic dw, input int mode, output int done_idx, output int pres);
        logic [8:0] o;
        int         hold;
        bit         used;
        logic       p, dc;
        done_idx = -1;
        pres     = 0;
        hold     = 0;
        used     = 0;
        for (int i = 0; i < 60 && done_idx < 0; i++) begin
            if (!used && mode == 1 && m_st == 2 && m_el == 5) begin hold = 3; used = 1; end
            if (!used && mode == 2 && m_st == 4 && m_el == 2) begin hold = 2; used = 1; end
            p  = (mode == 1) && (hold > 0);
            dc = !((mode == 2) && (hold > 0));
            if (hold > 0) hold--;
            cyc(1'b1, i == 0, p, dw, dc, 1'b1, o);
            pres += int'(o[1]);
            if (o[0]) done_idx = i;
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, o);
        chk("return_idle", o, 9'b0);
    endtask

    initial begin
        vec_t       tbl[$];
        logic [8:0] o;
        int         di, np;
        int         dones[$];

        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b000_0000_00, "door_open_start"});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'b000_0000_00, "idle_pause"});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'b000_0000_00, "start_accept"});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'b001_1001_00, "fill_t0"});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'b001_1001_00, "fill_t1_start_ign"});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'b001_0001_00, "fill_paused"});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b001_0001_00, "fill_door_open"});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'b001_1001_00, "fill_t2"});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'b001_1001_10, "fill_pre"});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'b010_0011_00, "wash_t0"});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b010_0011_00, "wash_rst_low"});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'b000_0000_00, "after_reset"});

        rst = 1'b0;
        bus.start = 1'b0; bus.pause = 1'b0; bus.double_wash = 1'b0; bus.door_closed = 1'b0;
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, o);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, o);

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].d, tbl[i].dc, 1'b0, o);
            chk(tbl[i].name, o, tbl[i].exp);
        end

        run_cycle(1'b0, 0, di, np);
        chk_int("default_done_idx", di, 24);
        chk_int("default_pre_count", np, 4);

        run_cycle(1'b1, 0, di, np);
        chk_int("dw_done_idx", di, 32);
        chk_int("dw_pre_count", np, 5);

        run_cycle(1'b0, 1, di, np);
        chk_int("pause_done_idx", di, 27);

        run_cycle(1'b0, 2, di, np);
        chk_int("door_spin_done_idx", di, 26);

        // Reset in RINSE, then restart.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, o);
        for (int i = 0; i < 40 && m_st != 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, o);
        chk_int("reached_rinse", m_st, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, o);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, o);
        chk("rinse_rst_outputs", o, 9'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, o);
        chk("restart_fill", o, 9'b001_1001_00);
        for (int i = 0; i < 40 && m_st != 0; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, o);

        // Start held high: back-to-back cycles with one IDLE cycle in between.
        for (int i = 0; i < 60; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, o);
            if (o[0]) dones.push_back(i);
        end
        chk_int("held_done_count", dones.size(), 2);
        if (dones.size() >= 2) begin
            chk_int("held_first_done", dones[0], 24);
            chk_int("held_period", dones[1] - dones[0], 25);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, o);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 7) != 0, 1'b1, o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
